// File: rtl/ft_lockstep_recovery_pkg.sv
// rtl/ft_lockstep_recovery_pkg.sv - shared types and helpers for the lockstep register-file guard
package ft_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SYNC    = 2'd1,
        RESTORE = 2'd2
    } state_e;

    localparam logic [1:0] FAULT_NONE = 2'd3;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/ft_lockstep_recovery_if.sv
// rtl/ft_lockstep_recovery_if.sv - lane write-back and fetch-control bundle for the lockstep guard
interface ft_lockstep_recovery_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int CNT_WIDTH  = 8
);
    logic [NUM_LANES-1:0]                 we_i;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0]                spc_i;
    logic [DATA_WIDTH-1:0]                spc_o;
    logic [ADDR_WIDTH-1:0]                addr_o;
    logic [DATA_WIDTH-1:0]                data_o;
    logic                                 fetch_block_o;
    logic                                 rollback_o;
    logic [1:0]                           fault_lane_o;
    logic [CNT_WIDTH-1:0]                 err_count_o;

    modport slave (
        input  we_i, addr_i, data_i, spc_i,
        output spc_o, addr_o, data_o, fetch_block_o, rollback_o, fault_lane_o, err_count_o
    );
    modport master (
        output we_i, addr_i, data_i, spc_i,
        input  spc_o, addr_o, data_o, fetch_block_o, rollback_o, fault_lane_o, err_count_o
    );
endinterface

// File: rtl/ft_lockstep_recovery_voter.sv
// rtl/ft_lockstep_recovery_voter.sv - lane comparator: agree flag, voted (TMR) or lane-0 (DMR) value, outvoted lane
module ft_voter
    import ft_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_LANES = 2
) (
    input  logic [NUM_LANES-1:0][WIDTH-1:0] in_i,
    output logic                            agree_o,
    output logic [WIDTH-1:0]                voted_o,
    output logic [1:0]                      lane_o
);
    if (NUM_LANES == 3) begin : g_tmr
        logic [WIDTH-1:0] w_maj;
        logic [2:0]       w_diff;

        always_comb begin
            w_maj = '0;
            for (int b = 0; b < WIDTH; b++) begin
                w_maj[b] = majority3(in_i[0][b], in_i[1][b], in_i[2][b]);
            end
        end

        always_comb begin
            w_diff  = '0;
            for (int k = 0; k < 3; k++) begin
                w_diff[k] = (in_i[k] != w_maj);
            end
            agree_o = (w_diff == 3'b000);
            voted_o = w_maj;
            // Only a single outlier can be blamed; several outliers leave the culprit unknown
            case (w_diff)
                3'b001:  lane_o = 2'd0;
                3'b010:  lane_o = 2'd1;
                3'b100:  lane_o = 2'd2;
                default: lane_o = FAULT_NONE;
            endcase
        end
    end else begin : g_dmr
        assign agree_o = (in_i[0] == in_i[1]);
        assign voted_o = in_i[0];
        assign lane_o  = FAULT_NONE;
    end
endmodule

// File: rtl/ft_lockstep_recovery.sv
// rtl/ft_lockstep_recovery.sv - N-lane lockstep register-file guard with resync sweep and PC rollback
module ft_lockstep_recovery
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    ft_lockstep_recovery_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int WORD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    if (NUM_LANES != 2 && NUM_LANES != 3) begin : g_bad_lanes
        $error("ft_lockstep_recovery: NUM_LANES must be 2 or 3");
    end

    state_e                                           r_state, w_next_state;
    logic [ADDR_WIDTH-1:0]                            r_idx;
    logic [NUM_LANES-1:0][DEPTH-1:0][DATA_WIDTH-1:0]  r_copy;
    logic [ADDR_WIDTH-1:0]                            r_addr;
    logic [DATA_WIDTH-1:0]                            r_data;
    logic [DATA_WIDTH-1:0]                            r_spc;
    logic [CNT_WIDTH-1:0]                             r_cnt;
    logic [1:0]                                       r_fault;

    logic [NUM_LANES-1:0][WORD_W-1:0]     w_wr_words;
    logic                                 w_wr_agree;
    logic [WORD_W-1:0]                    w_wr_vote;
    logic [1:0]                           w_wr_lane;
    logic                                 w_vote_we;
    logic [ADDR_WIDTH-1:0]                w_vote_addr;
    logic [DATA_WIDTH-1:0]                w_vote_data;
    logic                                 w_commit;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_rd_words;
    logic [DATA_WIDTH-1:0]                w_golden;
    logic                                 w_gold_agree;
    logic [1:0]                           w_gold_lane;
    logic                                 w_unused_gold;
    logic                                 w_fetch_block;
    logic                                 w_rollback;

    // Address/data are masked when a lane is not writing so idle lanes always compare equal
    always_comb begin
        w_wr_words = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (bus.we_i[k]) w_wr_words[k] = {1'b1, bus.addr_i[k], bus.data_i[k]};
        end
    end

    ft_voter #(.WIDTH(WORD_W), .NUM_LANES(NUM_LANES)) u_wr_voter (
        .in_i(w_wr_words), .agree_o(w_wr_agree), .voted_o(w_wr_vote), .lane_o(w_wr_lane)
    );

    assign {w_vote_we, w_vote_addr, w_vote_data} = w_wr_vote;
    assign w_commit = w_vote_we && (w_wr_agree || NUM_LANES == 3);

    always_comb begin
        w_rd_words = '0;
        for (int k = 0; k < NUM_LANES; k++) w_rd_words[k] = r_copy[k][r_idx];
    end

    ft_voter #(.WIDTH(DATA_WIDTH), .NUM_LANES(NUM_LANES)) u_gold_voter (
        .in_i(w_rd_words), .agree_o(w_gold_agree), .voted_o(w_golden), .lane_o(w_gold_lane)
    );

    assign w_unused_gold = ^{w_gold_agree, w_gold_lane};

    always_comb begin
        w_next_state  = r_state;
        w_fetch_block = 1'b0;
        w_rollback    = 1'b0;
        case (r_state)
            RUN:     if (!w_wr_agree) w_next_state = SYNC;
            SYNC: begin
                w_fetch_block = 1'b1;
                if (&r_idx) w_next_state = RESTORE;
            end
            RESTORE: begin
                w_fetch_block = 1'b1;
                w_rollback    = (NUM_LANES == 2);
                w_next_state  = RUN;
            end
            default: w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= RUN;
            r_idx   <= '0;
            r_copy  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_spc   <= '0;
            r_cnt   <= '0;
            r_fault <= FAULT_NONE;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                RUN: begin
                    r_idx <= '0;
                    if (w_commit) begin
                        for (int k = 0; k < NUM_LANES; k++) r_copy[k][w_vote_addr] <= w_vote_data;
                        r_addr <= w_vote_addr;
                        r_data <= w_vote_data;
                    end
                    if (w_wr_agree) begin
                        r_spc <= bus.spc_i;
                    end else begin
                        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        if (NUM_LANES == 3) r_fault <= w_wr_lane;
                    end
                end
                SYNC: begin
                    for (int k = 0; k < NUM_LANES; k++) r_copy[k][r_idx] <= w_golden;
                    r_addr <= r_idx;
                    r_data <= w_golden;
                    r_idx  <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.spc_o         = r_spc;
    assign bus.addr_o        = (r_state == SYNC) ? r_idx : r_addr;
    assign bus.data_o        = (r_state == SYNC) ? w_golden : r_data;
    assign bus.fetch_block_o = w_fetch_block;
    assign bus.rollback_o    = w_rollback;
    assign bus.fault_lane_o  = r_fault;
    assign bus.err_count_o   = r_cnt;
endmodule

// File: tb/tb_ft_lockstep_recovery.sv
// tb/tb_ft_lockstep_recovery.sv - scoreboard bench driving a DMR and a TMR instance side by side
module tb_ft_lockstep_recovery;
    typedef struct {
        int          cyc;
        bit          tmr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] spc;
        logic        fb;
        logic        rb;
        logic [1:0]  fl;
        logic [7:0]  cnt;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    logic [31:0] e_spc;
    logic [7:0]  e_cnt_d, e_cnt_t;
    logic [1:0]  e_fl_t;
    bit          filled, t500;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ft_lockstep_recovery_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LANES(2), .CNT_WIDTH(8)) if_dmr ();
    ft_lockstep_recovery_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LANES(3), .CNT_WIDTH(8)) if_tmr ();

    ft_lockstep_recovery #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LANES(2), .CNT_WIDTH(8)) u_dmr (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_dmr)
    );
    ft_lockstep_recovery #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LANES(3), .CNT_WIDTH(8)) u_tmr (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_tmr)
    );

    exp_t        m_e;
    logic [4:0]  a_addr;
    logic [31:0] a_data, a_spc;
    logic        a_fb, a_rb;
    logic [1:0]  a_fl;
    logic [7:0]  a_cnt;

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            m_e = sb_q.pop_front();
            if (m_e.tmr) begin
                a_addr = if_tmr.addr_o; a_data = if_tmr.data_o; a_spc = if_tmr.spc_o;
                a_fb = if_tmr.fetch_block_o; a_rb = if_tmr.rollback_o;
                a_fl = if_tmr.fault_lane_o; a_cnt = if_tmr.err_count_o;
            end else begin
                a_addr = if_dmr.addr_o; a_data = if_dmr.data_o; a_spc = if_dmr.spc_o;
                a_fb = if_dmr.fetch_block_o; a_rb = if_dmr.rollback_o;
                a_fl = if_dmr.fault_lane_o; a_cnt = if_dmr.err_count_o;
            end
            checks++;
            if (m_e.cyc != cyc || a_addr !== m_e.addr || a_data !== m_e.data || a_spc !== m_e.spc ||
                a_fb !== m_e.fb || a_rb !== m_e.rb || a_fl !== m_e.fl || a_cnt !== m_e.cnt) begin
                errors++;
                $display("FAIL %s %s cyc=%0d(due %0d) got addr=%0d data=%0d spc=%h fb=%b rb=%b fl=%0d cnt=%0d required addr=%0d data=%0d spc=%h fb=%b rb=%b fl=%0d cnt=%0d",
                         m_e.tmr ? "tmr" : "dmr", m_e.name, cyc, m_e.cyc, a_addr, a_data, a_spc, a_fb, a_rb,
                         a_fl, a_cnt, m_e.addr, m_e.data, m_e.spc, m_e.fb, m_e.rb, m_e.fl, m_e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit tmr, input int a, input logic [31:0] d, input logic fb, input logic rb,
                        input logic [1:0] fl, input logic [7:0] cnt, input string nm);
        exp_t e;
        e.cyc = cyc + 1; e.tmr = tmr; e.addr = a[4:0]; e.data = d; e.spc = e_spc;
        e.fb = fb; e.rb = rb; e.fl = fl; e.cnt = cnt; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic exp_both(input int a, input logic [31:0] dd, input logic [31:0] dt,
                            input logic fb, input logic rbd, input string nm);
        push(1'b0, a, dd, fb, rbd, 2'd3, e_cnt_d, nm);
        push(1'b1, a, dt, fb, 1'b0, e_fl_t, e_cnt_t, nm);
    endtask

    function automatic logic [31:0] gold_d(input int k);
        return filled ? 32'(k * 10) : 32'd0;
    endfunction

    function automatic logic [31:0] gold_t(input int k);
        return (t500 && k == 10) ? 32'd500 : gold_d(k);
    endfunction

    task automatic set_all(input logic we, input int a, input int d, input logic [31:0] spc);
        if_dmr.we_i = {2{we}};
        if_tmr.we_i = {3{we}};
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                if_dmr.addr_i[k] = a[4:0];
                if_dmr.data_i[k] = d;
            end
            if_tmr.addr_i[k] = a[4:0];
            if_tmr.data_i[k] = d;
        end
        if_dmr.spc_i = spc;
        if_tmr.spc_i = spc;
    endtask

    task automatic set_idle();
        set_all(1'b0, 0, 0, e_spc);
    endtask

    task automatic set_junk();
        set_all(1'b1, 3, 1, 32'h99);
        if_dmr.we_i = 2'b01;
        if_tmr.we_i = 3'b101;
    endtask

    task automatic set_mismatch();
        set_all(1'b1, 10, 500, 32'h84);
        if_dmr.we_i      = 2'b10;
        if_dmr.data_i[1] = 32'd777;
        if_tmr.data_i[2] = 32'd99;
    endtask

    task automatic reset_model();
        e_spc = 32'h0; e_cnt_d = 8'd0; e_cnt_t = 8'd0; e_fl_t = 2'd3; filled = 1'b0; t500 = 1'b0;
    endtask

    task automatic stall_seq();
        set_mismatch();
        e_cnt_d = e_cnt_d + 8'd1;
        e_cnt_t = e_cnt_t + 8'd1;
        e_fl_t  = 2'd2;
        t500    = 1'b1;
        for (int k = 0; k < 32; k++) begin
            exp_both(k, gold_d(k), gold_t(k), 1'b1, 1'b0, "sync");
            tick();
            set_junk();
        end
        exp_both(31, gold_d(31), gold_t(31), 1'b1, 1'b1, "restore");
        tick();
        set_junk();
        exp_both(31, gold_d(31), gold_t(31), 1'b0, 1'b0, "run_after");
        tick();
        set_idle();
    endtask

    initial begin
        reset_model();
        rst_n = 1'b0;
        set_idle();
        exp_both(0, 0, 0, 1'b0, 1'b0, "reset1"); tick();
        exp_both(0, 0, 0, 1'b0, 1'b0, "reset2"); tick();
        rst_n = 1'b1;
        exp_both(0, 0, 0, 1'b0, 1'b0, "reset_rel"); tick();

        // Forced sweep straight after reset: every copy must read back zero (TMR also takes a voted write)
        stall_seq();

        rst_n = 1'b0; reset_model(); set_idle();
        exp_both(0, 0, 0, 1'b0, 1'b0, "reset3"); tick();
        rst_n = 1'b1;
        exp_both(0, 0, 0, 1'b0, 1'b0, "reset3_rel"); tick();

        e_spc = 32'h80;
        for (int i = 0; i < 32; i++) begin
            set_all(1'b1, i, i * 10, 32'h80);
            exp_both(i, 32'(i * 10), 32'(i * 10), 1'b0, 1'b0, "fill");
            tick();
        end
        filled = 1'b1;

        stall_seq();
        stall_seq();

        set_mismatch();
        e_cnt_d = e_cnt_d + 8'd1;
        e_cnt_t = e_cnt_t + 8'd1;
        exp_both(0, gold_d(0), gold_t(0), 1'b1, 1'b0, "sync_pre_rst");
        tick();
        for (int k = 1; k <= 5; k++) begin
            set_junk();
            exp_both(k, gold_d(k), gold_t(k), 1'b1, 1'b0, "sync_pre_rst");
            tick();
        end
        rst_n = 1'b0; reset_model(); set_idle();
        exp_both(0, 0, 0, 1'b0, 1'b0, "midsync_rst"); tick();
        rst_n = 1'b1;
        exp_both(0, 0, 0, 1'b0, 1'b0, "midsync_rel"); tick();

        for (int n = 0; n < 259; n++) begin
            set_idle();
            if_dmr.we_i      = 2'b10;
            if_dmr.addr_i[1] = 5'd10;
            if_dmr.data_i[1] = 32'd777;
            tick();
            set_idle();
            repeat (33) tick();
        end
        set_idle();
        push(1'b0, 31, 32'd0, 1'b0, 1'b0, 2'd3, 8'hFF, "saturate");
        push(1'b1, 0, 32'd0, 1'b0, 1'b0, 2'd3, 8'd0, "tmr_idle");
        tick();

        for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
